// File: rtl/mips_instr_encoder.sv
// MIPS instruction encoder: packs mnemonic + fields into a 32-bit word
// and streams it into instruction memory, one word per two cycles.
module mips_instr_encoder #(
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              restart,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_op,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              err_valid,
   output logic [3:0]        err_op
);

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      FULL
   } state_t;

   state_t      state;
   logic        rdy_q;
   logic        we_q;
   logic        legal;
   logic        xfer;
   logic [31:0] enc;

   // restart gates the handshake and any in-flight strobe in the same cycle
   assign in_ready = rdy_q & ~restart;
   assign mem_we   = we_q & ~restart;
   assign xfer     = in_valid & in_ready;

   always_comb begin
      enc   = '0;
      legal = 1'b1;
      case (in_op)
         4'd0:  enc = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100000};
         4'd1:  enc = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100010};
         4'd2:  enc = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100100};
         4'd3:  enc = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100101};
         4'd4:  enc = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b101010};
         4'd5:  enc = {6'b000000, in_rs, 10'b0, 5'b0, 6'b001000};
         4'd6:  enc = {6'b100011, in_rs, in_rt, in_imm};
         4'd7:  enc = {6'b101011, in_rs, in_rt, in_imm};
         4'd8:  enc = {6'b000100, in_rs, in_rt, in_imm};
         4'd9:  enc = {6'b000101, in_rs, in_rt, in_imm};
         4'd10: enc = {6'b001000, in_rs, in_rt, in_imm};
         4'd11: enc = {6'b001100, in_rs, in_rt, in_imm};
         4'd12: enc = {6'b000010, in_target};
         4'd13: enc = {6'b000011, in_target};
         default: legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         rdy_q     <= 1'b1;
         we_q      <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         count     <= '0;
         full      <= 1'b0;
         err_valid <= 1'b0;
         err_op    <= '0;
      end else begin
         err_valid <= 1'b0;
         if (xfer && !legal) begin
            err_valid <= 1'b1;
            err_op    <= in_op;
         end
         if (restart) begin
            state    <= IDLE;
            rdy_q    <= 1'b1;
            we_q     <= 1'b0;
            mem_addr <= '0;
            count    <= '0;
            full     <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (xfer && legal) begin
                     mem_wdata <= enc;
                     we_q      <= 1'b1;
                     rdy_q     <= 1'b0;
                     state     <= WRITE;
                  end
               end
               WRITE: begin
                  we_q     <= 1'b0;
                  mem_addr <= mem_addr + 1'b1;
                  count    <= count + 1'b1;
                  if (count + 1'b1 == DEPTH_C) begin
                     full  <= 1'b1;
                     state <= FULL;
                  end else begin
                     rdy_q <= 1'b1;
                     state <= IDLE;
                  end
               end
               default: begin
                  we_q  <= 1'b0;
                  rdy_q <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench for mips_instr_encoder (ADDR_W=2, DEPTH=4 so the
// fill-to-FULL and address-wrap cases are reachable quickly).
module tb_mips_instr_encoder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        restart = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  in_op = '0;
   logic [4:0]  in_rs = '0;
   logic [4:0]  in_rt = '0;
   logic [4:0]  in_rd = '0;
   logic [15:0] in_imm = '0;
   logic [25:0] in_target = '0;
   logic        mem_we;
   logic [1:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [2:0]  count;
   logic        full;
   logic        err_valid;
   logic [3:0]  err_op;

   int total = 0;
   int bad = 0;
   logic [1:0]  wa[$];
   logic [31:0] wd[$];
   logic        ok;

   mips_instr_encoder #(.ADDR_W(2), .DEPTH(4)) dut (
      .clk(clk), .reset(reset), .restart(restart),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
      .in_imm(in_imm), .in_target(in_target),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .count(count), .full(full),
      .err_valid(err_valid), .err_op(err_op)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      #1;
      if (mem_we) begin
         wa.push_back(mem_addr);
         wd.push_back(mem_wdata);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // called at a negedge; returns at the negedge after the accepting edge
   task automatic send(input logic [3:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic [15:0] imm, input logic [25:0] tg,
                       input int lim, output logic acc);
      in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
      in_imm = imm; in_target = tg; in_valid = 1'b1;
      acc = 1'b0;
      for (int n = 0; n < lim; n++) begin
         #1;
         if (in_ready) begin
            @(posedge clk);
            @(negedge clk);
            acc = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_restart();
      restart = 1'b1;
      #1;
      chk("rdy_in_restart", in_ready, 0);
      @(negedge clk);
      restart = 1'b0;
   endtask

   task automatic clr();
      wa.delete();
      wd.delete();
   endtask

   function automatic logic [31:0] add_w(input logic [4:0] rd);
      return 32'h0022_0020 | (32'(rd) << 11);
   endfunction

   initial begin
      cyc(2);
      reset = 1'b0;
      #1;
      chk("rst_ready", in_ready, 1);
      chk("rst_we", mem_we, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_count", count, 0);
      chk("rst_full", full, 0);
      chk("rst_err", err_valid, 0);
      chk("rst_errop", err_op, 0);
      @(negedge clk);

      // ADD r3 = r1 + r2
      send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 10, ok);
      chk("t1_acc", ok, 1);
      in_valid = 1'b0;
      cyc(3);
      chk("t1_n", wa.size(), 1);
      chk("t1_addr", wa[0], 0);
      chk("t1_data", wd[0], 32'h0022_1820);
      chk("t1_count", count, 1);
      do_restart();
      clr();

      // LW then J back-to-back
      send(4'd6, 5'd4, 5'd5, 5'd0, 16'h0010, 26'h0, 10, ok);
      chk("t2_acc0", ok, 1);
      #1;
      chk("t2_rdy_w0", in_ready, 0);
      send(4'd12, 5'd0, 5'd0, 5'd0, 16'h0, 26'h40, 10, ok);
      chk("t2_acc1", ok, 1);
      in_valid = 1'b0;
      #1;
      chk("t2_rdy_w1", in_ready, 0);
      cyc(3);
      chk("t2_n", wa.size(), 2);
      chk("t2_a0", wa[0], 0);
      chk("t2_d0", wd[0], 32'h8C85_0010);
      chk("t2_a1", wa[1], 1);
      chk("t2_d1", wd[1], 32'h0800_0040);
      do_restart();
      clr();

      // JR (rt/rd dropped), BNE, ANDI
      send(4'd5, 5'd31, 5'd7, 5'd9, 16'h0, 26'h0, 10, ok);
      send(4'd9, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 10, ok);
      send(4'd11, 5'd0, 5'd8, 5'd0, 16'h00FF, 26'h0, 10, ok);
      in_valid = 1'b0;
      cyc(3);
      chk("t3_n", wa.size(), 3);
      chk("t3_jr", wd[0], 32'h03E0_0008);
      chk("t3_bne", wd[1], 32'h1422_FFFF);
      chk("t3_andi", wd[2], 32'h3008_00FF);
      chk("t3_a2", wa[2], 2);
      chk("t3_count", count, 3);
      do_restart();
      clr();

      // illegal opcode
      send(4'd14, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1, 10, ok);
      in_valid = 1'b0;
      chk("t4_acc", ok, 1);
      chk("t4_errv", err_valid, 1);
      chk("t4_errop", err_op, 14);
      chk("t4_rdy", in_ready, 1);
      @(negedge clk);
      chk("t4_errv_off", err_valid, 0);
      chk("t4_errop_hold", err_op, 14);
      cyc(2);
      chk("t4_n", wa.size(), 0);
      chk("t4_count", count, 0);

      // fill to FULL, 5th request blocked until restart
      for (int k = 1; k <= 4; k++) begin
         send(4'd0, 5'd1, 5'd2, 5'(k), 16'h0, 26'h0, 10, ok);
         chk("t5_acc", ok, 1);
      end
      send(4'd0, 5'd1, 5'd2, 5'd5, 16'h0, 26'h0, 8, ok);
      chk("t5_acc5", ok, 0);
      chk("t5_n", wa.size(), 4);
      for (int k = 0; k < 4; k++) begin
         chk("t5_addr", wa[k], k);
         chk("t5_data", wd[k], add_w(5'(k + 1)));
      end
      #1;
      chk("t5_full", full, 1);
      chk("t5_rdy", in_ready, 0);
      chk("t5_count", count, 4);
      chk("t5_wrap", mem_addr, 0);
      @(negedge clk);
      clr();
      do_restart();
      chk("t5_cnt_rs", count, 0);
      chk("t5_full_rs", full, 0);
      send(4'd0, 5'd1, 5'd2, 5'd5, 16'h0, 26'h0, 10, ok);
      chk("t5_acc_rs", ok, 1);
      in_valid = 1'b0;
      cyc(3);
      chk("t5_n_rs", wa.size(), 1);
      chk("t5_a_rs", wa[0], 0);
      chk("t5_d_rs", wd[0], add_w(5'd5));
      do_restart();
      clr();

      // restart during WRITE suppresses the strobe
      send(4'd0, 5'd1, 5'd2, 5'd6, 16'h0, 26'h0, 10, ok);
      in_valid = 1'b0;
      restart = 1'b1;
      #1;
      chk("t6_we_sup", mem_we, 0);
      @(negedge clk);
      restart = 1'b0;
      cyc(2);
      chk("t6_n0", wa.size(), 0);
      chk("t6_count", count, 0);
      send(4'd0, 5'd1, 5'd2, 5'd7, 16'h0, 26'h0, 10, ok);
      in_valid = 1'b0;
      cyc(3);
      chk("t6_n", wa.size(), 1);
      chk("t6_a", wa[0], 0);
      chk("t6_d", wd[0], add_w(5'd7));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
